axi_aw_decerr_gen: RTL and testbench
====================================

AXI_AW_DECERR_GEN -- requirements
Module: axi_aw_decerr_gen

Interface
REQ-001 Parameter AXI_ID_IN, default 16, width of AW ID and error ID.
REQ-002 Parameter AXI_USER_W, default 6, width of AW user and error user.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 awvalid_i / awready_o  input / output  1 / 1  slave-side AW handshake.
REQ-006 awid_i, awuser_i, awlen_i  input  AXI_ID_IN, AXI_USER_W, 8  AW ID, user and burst length (beats-1).
REQ-007 aw_dec_err_i  input  1  address decoder miss for the current AW; valid with awvalid_i.
REQ-008 aw_fwd_valid_o / aw_fwd_ready_i  output / input  1 / 1  AW forward handshake toward the target.
REQ-009 wvalid_i, wlast_i / wready_o  input / output  1, 1 / 1  W channel of the errored burst.
REQ-010 incr_req_o, sample_awdata_info_o  output  1  pulses to the write-response allocator.
REQ-011 error_req_o / error_gnt_i  output / input  1 / 1  error-response request and grant.
REQ-012 error_id_o, error_user_o  output  AXI_ID_IN, AXI_USER_W  ID/user of the errored AW.
REQ-013 full_counter_i, outstanding_trans_i  input  1  allocator counter status.

Function
REQ-014 FSM states: IDLE, DRAIN_W, REQ_B, WAIT_B; reset state IDLE.
REQ-015 IDLE, aw_dec_err_i=0: aw_fwd_valid_o = awvalid_i & ~full_counter_i; awready_o = aw_fwd_ready_i & ~full_counter_i.
REQ-016 IDLE, good AW handshake (awvalid_i & awready_o): incr_req_o=1 in that cycle only; state stays IDLE.
REQ-017 full_counter_i=1 in IDLE: good AW stalls (awready_o=0, aw_fwd_valid_o=0, incr_req_o=0).
REQ-018 IDLE, awvalid_i & aw_dec_err_i: awready_o=1 regardless of full_counter_i; aw_fwd_valid_o=0; sample_awdata_info_o=1 for one cycle; awlen_i is captured; the beat counter is cleared; next state DRAIN_W.
REQ-019 error_id_o/error_user_o are driven from awid_i/awuser_i in the sample cycle and hold the captured values in all other states.
REQ-020 DRAIN_W: wready_o=1; awready_o=0; each wvalid_i beat increments a 9-bit beat counter; a beat with wlast_i=1 moves the FSM to REQ_B next cycle.
REQ-021 wready_o=0 in all states other than DRAIN_W.
REQ-022 Beats are consumed until wlast_i regardless of awlen_i; a wlast_i beat whose count differs from awlen_i+1 is a length mismatch.
REQ-023 REQ_B: error_req_o=1; on error_gnt_i=1 drop error_req_o next cycle and move to WAIT_B.
REQ-024 The grant is honoured by the allocator only when outstanding_trans_i=0; the block holds error_req_o without timeout.
REQ-025 WAIT_B: error_req_o=0; return to IDLE on the first cycle error_gnt_i=0; no AW accepted in WAIT_B.
REQ-026 error_gnt_i outside REQ_B/WAIT_B is ignored.
REQ-027 The beat counter saturates at 511.

Reset
REQ-028 While rst=1: state IDLE; beat counter, captured len/ID/user and stats are 0; awready_o, aw_fwd_valid_o, wready_o, incr_req_o, sample_awdata_info_o and error_req_o are 0.
REQ-029 rst asserted in any state aborts the operation; the first cycle after release behaves as IDLE.

Configuration
REQ-030 Macro AXI_DECERR_STATS_EN defined: add outputs err_count_o (16 bits) and len_mismatch_o (1 bit).
REQ-031 err_count_o increments on each errored-AW accept and saturates at 0xFFFF.
REQ-032 len_mismatch_o is sticky, set per REQ-022 and cleared only by reset.
REQ-033 Macro AXI_DECERR_STATS_EN undefined: err_count_o and len_mismatch_o are absent and there is no stats logic.

Verification
REQ-034 Good AW, awlen=3, aw_fwd_ready_i=1, full=0 -> same-cycle handshake; incr_req_o one cycle; wready_o stays 0.
REQ-035 Errored AW id=0x5A, user=0x2, awlen=3; 4 W beats with wlast on the 4th -> sample pulse with error_id_o=0x5A; 4 beats accepted; error_req_o from the next cycle.
REQ-036 In REQ_B: error_gnt_i high 2 cycles then low -> error_req_o drops after the first gnt cycle; IDLE after gnt falls; next AW accepted.
REQ-037 full_counter_i=1 with good AW pending -> awready_o=0 until full deasserts; an errored AW in the same condition is still accepted.
REQ-038 With STATS_EN: awlen=3 but wlast on beat 2 -> REQ_B entered; len_mismatch_o=1; err_count_o=1.
REQ-039 rst pulse in DRAIN_W after 2 beats -> all outputs 0; IDLE; counter 0; no error_req_o.

Source files
------------

// File: rtl/axi_aw_decerr_gen.sv
// AW decode-error responder: sinks errored write bursts
// and requests a DECERR B response from the allocator.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   awvalid_i/awready_o  slave-side AW handshake
//   awid_i/awuser_i      AW ID and user
//   awlen_i              AW burst length (beats-1)
//   aw_dec_err_i         decoder miss for the current AW
//   aw_fwd_valid_o       AW forward valid toward target
//   aw_fwd_ready_i       AW forward ready from target
//   wvalid_i/wlast_i     W channel of the errored burst
//   wready_o             W ready, only while draining
//   incr_req_o           good AW accepted (allocator pulse)
//   sample_awdata_info_o errored AW accepted (sample pulse)
//   error_req_o          error-response request
//   error_gnt_i          error-response grant
//   error_id_o           ID of the errored AW
//   error_user_o         user of the errored AW
//   full_counter_i       allocator counter full
//   outstanding_trans_i  allocator has transactions in flight
//   err_count_o          errored-AW count, saturating
//   len_mismatch_o       sticky beat-count/awlen mismatch
// The last two exist only with AXI_DECERR_STATS_EN.
module axi_aw_decerr_gen #(
  parameter int AXI_ID_IN  = 16,
  parameter int AXI_USER_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [AXI_ID_IN-1:0]  awid_i,
  input  logic [AXI_USER_W-1:0] awuser_i,
  input  logic [7:0]            awlen_i,
  input  logic                  aw_dec_err_i,
  output logic                  aw_fwd_valid_o,
  input  logic                  aw_fwd_ready_i,
  input  logic                  wvalid_i,
  input  logic                  wlast_i,
  output logic                  wready_o,
  output logic                  incr_req_o,
  output logic                  sample_awdata_info_o,
  output logic                  error_req_o,
  input  logic                  error_gnt_i,
  output logic [AXI_ID_IN-1:0]  error_id_o,
  output logic [AXI_USER_W-1:0] error_user_o,
  input  logic                  full_counter_i,
  input  logic                  outstanding_trans_i
`ifdef AXI_DECERR_STATS_EN
  ,
  output logic [15:0]           err_count_o,
  output logic                  len_mismatch_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN_W,
    REQ_B,
    WAIT_B
  } state_e;

  state_e                  state_q;
  state_e                  state_d;
  logic [8:0]              beat_q;
  logic [8:0]              beat_inc;
  logic [7:0]              len_q;
  logic [AXI_ID_IN-1:0]    id_q;
  logic [AXI_USER_W-1:0]   user_q;
  logic                    err_aw;
  logic                    gnt_ok;
  logic                    beat;

  assign err_aw   = awvalid_i & aw_dec_err_i;
  // The allocator only honours the grant with nothing in flight.
  assign gnt_ok   = error_gnt_i & ~outstanding_trans_i;
  assign beat     = (state_q == DRAIN_W) & wvalid_i;
  assign beat_inc = (&beat_q) ? beat_q : beat_q + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (err_aw) state_d = DRAIN_W;
      DRAIN_W: if (wvalid_i & wlast_i) state_d = REQ_B;
      REQ_B:   if (gnt_ok) state_d = WAIT_B;
      WAIT_B:  if (!error_gnt_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    awready_o            = 1'b0;
    aw_fwd_valid_o       = 1'b0;
    wready_o             = 1'b0;
    incr_req_o           = 1'b0;
    sample_awdata_info_o = 1'b0;
    error_req_o          = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (err_aw) begin
            awready_o            = 1'b1;
            sample_awdata_info_o = 1'b1;
          end else begin
            aw_fwd_valid_o = awvalid_i & ~full_counter_i;
            awready_o      = aw_fwd_ready_i & ~full_counter_i;
            incr_req_o     = awvalid_i & aw_fwd_ready_i
                           & ~full_counter_i;
          end
        end
        DRAIN_W: wready_o    = 1'b1;
        REQ_B:   error_req_o = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      id_q   <= '0;
      user_q <= '0;
      len_q  <= '0;
    end else begin
      len_q <= sample_awdata_info_o ? awlen_i : len_q;
      if (sample_awdata_info_o) begin
        beat_q <= '0;
        id_q   <= awid_i;
        user_q <= awuser_i;
      end else if (beat) begin
        beat_q <= beat_inc;
      end
    end
  end

  assign error_id_o   = sample_awdata_info_o ? awid_i : id_q;
  assign error_user_o = sample_awdata_info_o ? awuser_i : user_q;

`ifdef AXI_DECERR_STATS_EN
  logic mis_beat;

  // beat_inc is the count including the wlast beat.
  assign mis_beat = beat & wlast_i
                  & (beat_inc != ({1'b0, len_q} + 9'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_o    <= '0;
      len_mismatch_o <= 1'b0;
    end else begin
      if (sample_awdata_info_o && (err_count_o != 16'hFFFF))
        err_count_o <= err_count_o + 16'd1;
      if (mis_beat)
        len_mismatch_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_aw_decerr_gen.sv
// Bench for axi_aw_decerr_gen: directed table, corner
// sequences and randomized traffic against a burst model.
module tb_axi_aw_decerr_gen;

  logic        clk;
  logic        rst;
  logic        awvalid_i;
  logic        awready_o;
  logic [15:0] awid_i;
  logic [5:0]  awuser_i;
  logic [7:0]  awlen_i;
  logic        aw_dec_err_i;
  logic        aw_fwd_valid_o;
  logic        aw_fwd_ready_i;
  logic        wvalid_i;
  logic        wlast_i;
  logic        wready_o;
  logic        incr_req_o;
  logic        sample_awdata_info_o;
  logic        error_req_o;
  logic        error_gnt_i;
  logic [15:0] error_id_o;
  logic [5:0]  error_user_o;
  logic        full_counter_i;
  logic        outstanding_trans_i;
`ifdef AXI_DECERR_STATS_EN
  logic [15:0] err_count_o;
  logic        len_mismatch_o;
`endif

  axi_aw_decerr_gen #(
    .AXI_ID_IN (16),
    .AXI_USER_W(6)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .awvalid_i           (awvalid_i),
    .awready_o           (awready_o),
    .awid_i              (awid_i),
    .awuser_i            (awuser_i),
    .awlen_i             (awlen_i),
    .aw_dec_err_i        (aw_dec_err_i),
    .aw_fwd_valid_o      (aw_fwd_valid_o),
    .aw_fwd_ready_i      (aw_fwd_ready_i),
    .wvalid_i            (wvalid_i),
    .wlast_i             (wlast_i),
    .wready_o            (wready_o),
    .incr_req_o          (incr_req_o),
    .sample_awdata_info_o(sample_awdata_info_o),
    .error_req_o         (error_req_o),
    .error_gnt_i         (error_gnt_i),
    .error_id_o          (error_id_o),
    .error_user_o        (error_user_o),
    .full_counter_i      (full_counter_i),
    .outstanding_trans_i (outstanding_trans_i)
`ifdef AXI_DECERR_STATS_EN
    ,
    .err_count_o         (err_count_o),
    .len_mismatch_o      (len_mismatch_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // {awready, fwd_valid, wready, incr, sample, error_req}
  function automatic logic [5:0] outs();
    return {awready_o, aw_fwd_valid_o, wready_o,
            incr_req_o, sample_awdata_info_o, error_req_o};
  endfunction

  typedef struct {
    string       nm;
    logic [6:0]  ctl;  // awv dec frdy full wv wl gnt
    logic [7:0]  len;
    logic [15:0] id;
    logic [5:0]  user;
    logic [5:0]  exp;
    logic [15:0] eid;
    logic [5:0]  euser;
  } vec_t;

  function automatic vec_t mk(string nm, logic [6:0] ctl,
                              logic [7:0] len,
                              logic [15:0] id,
                              logic [5:0] user,
                              logic [5:0] exp,
                              logic [15:0] eid,
                              logic [5:0] euser);
    vec_t v;
    v.nm = nm; v.ctl = ctl; v.len = len; v.id = id;
    v.user = user; v.exp = exp; v.eid = eid;
    v.euser = euser;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    {awvalid_i, aw_dec_err_i, aw_fwd_ready_i,
     full_counter_i, wvalid_i, wlast_i, error_gnt_i} = v.ctl;
    awlen_i  = v.len;
    awid_i   = v.id;
    awuser_i = v.user;
    outstanding_trans_i = 1'b0;
  endtask

  task automatic set_in(input logic [6:0] ctl,
                        input logic [7:0] len,
                        input logic [15:0] id);
    {awvalid_i, aw_dec_err_i, aw_fwd_ready_i,
     full_counter_i, wvalid_i, wlast_i, error_gnt_i} = ctl;
    awlen_i  = len;
    awid_i   = id;
    awuser_i = id[5:0];
    outstanding_trans_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Burst-level reference: where the errored burst is
  // (0 none, 1 taking W, 2 wanting B, 3 granted) plus
  // captured info and statistics as plain integers.
  int          m_ph;
  int          m_beats;
  int          m_len;
  logic [15:0] m_id;
  logic [5:0]  m_user;
  int          m_cnt;
  bit          m_mis;

  task automatic model_reset();
    m_ph = 0; m_beats = 0; m_len = 0;
    m_id = '0; m_user = '0; m_cnt = 0; m_mis = 0;
  endtask

  task automatic model_eval(output logic [5:0] e,
                            output logic [15:0] eid,
                            output logic [5:0] eu);
    bit err, good_rdy;
    e = '0; eid = m_id; eu = m_user;
    if (rst) return;
    err = awvalid_i && aw_dec_err_i;
    good_rdy = aw_fwd_ready_i && !full_counter_i;
    case (m_ph)
      0: if (err) begin
           e = 6'b100010; eid = awid_i; eu = awuser_i;
         end else begin
           e[5] = good_rdy;
           e[4] = awvalid_i && !full_counter_i;
           e[2] = awvalid_i && good_rdy;
         end
      1: e[3] = 1'b1;
      2: e[0] = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_step();
    case (m_ph)
      0: if (awvalid_i && aw_dec_err_i) begin
           m_ph = 1; m_beats = 0; m_len = awlen_i;
           m_id = awid_i; m_user = awuser_i;
           if (m_cnt < 65535) m_cnt++;
         end
      1: if (wvalid_i) begin
           if (m_beats < 511) m_beats++;
           if (wlast_i) begin
             if (m_beats != m_len + 1) m_mis = 1;
             m_ph = 2;
           end
         end
      2: if (error_gnt_i && !outstanding_trans_i) m_ph = 3;
      3: if (!error_gnt_i) m_ph = 0;
      default: m_ph = 0;
    endcase
  endtask

  vec_t tbl[$];

  initial begin
    logic [5:0]  e;
    logic [15:0] eid;
    logic [5:0]  eu;

    tbl.push_back(mk("idle0",      7'b0000000, 0, 16'h0,  0,
                     6'b000000, 16'h0,  0));
    tbl.push_back(mk("good_aw",    7'b1010000, 3, 16'h11, 1,
                     6'b110100, 16'h0,  0));
    tbl.push_back(mk("idle_w",     7'b0010100, 0, 16'h0,  0,
                     6'b100000, 16'h0,  0));
    tbl.push_back(mk("full_st1",   7'b1011000, 3, 16'h12, 1,
                     6'b000000, 16'h0,  0));
    tbl.push_back(mk("full_st2",   7'b1011000, 3, 16'h12, 1,
                     6'b000000, 16'h0,  0));
    tbl.push_back(mk("full_rel",   7'b1010000, 3, 16'h12, 1,
                     6'b110100, 16'h0,  0));
    tbl.push_back(mk("err_aw",     7'b1101000, 3, 16'h5A, 2,
                     6'b100010, 16'h5A, 2));
    tbl.push_back(mk("beat1",      7'b0000100, 0, 16'h0,  0,
                     6'b001000, 16'h5A, 2));
    tbl.push_back(mk("w_gap",      7'b0000000, 0, 16'h0,  0,
                     6'b001000, 16'h5A, 2));
    tbl.push_back(mk("beat2",      7'b0000100, 0, 16'h0,  0,
                     6'b001000, 16'h5A, 2));
    tbl.push_back(mk("beat3",      7'b1010100, 0, 16'h0,  0,
                     6'b001000, 16'h5A, 2));
    tbl.push_back(mk("beat4_last", 7'b0000110, 0, 16'h0,  0,
                     6'b001000, 16'h5A, 2));
    tbl.push_back(mk("req_b",      7'b0000000, 0, 16'h0,  0,
                     6'b000001, 16'h5A, 2));
    tbl.push_back(mk("gnt1",       7'b0000001, 0, 16'h0,  0,
                     6'b000001, 16'h5A, 2));
    tbl.push_back(mk("gnt2_wait",  7'b1010001, 0, 16'h77, 0,
                     6'b000000, 16'h5A, 2));
    tbl.push_back(mk("gnt_low",    7'b1010000, 0, 16'h77, 0,
                     6'b000000, 16'h5A, 2));
    tbl.push_back(mk("next_aw",    7'b1010000, 0, 16'h77, 0,
                     6'b110100, 16'h5A, 2));
    tbl.push_back(mk("gnt_idle",   7'b0000001, 0, 16'h0,  0,
                     6'b000000, 16'h5A, 2));
    tbl.push_back(mk("still_idle", 7'b0010000, 0, 16'h0,  0,
                     6'b100000, 16'h5A, 2));

    rst = 1'b1;
    set_in(7'b1010000, 0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {26'd0, outs()}, 0);
    chk("reset_id", {16'd0, error_id_o}, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step();
      drive(tbl[i]);
      @(negedge clk);
      chk({tbl[i].nm, "_outs"}, {26'd0, outs()}, {26'd0, tbl[i].exp});
      chk({tbl[i].nm, "_id"}, {16'd0, error_id_o}, {16'd0, tbl[i].eid});
      chk({tbl[i].nm, "_user"}, {26'd0, error_user_o},
          {26'd0, tbl[i].euser});
    end

    // Reset in the middle of a drained burst.
    step(); set_in(7'b1100000, 1, 16'h33);
    step(); set_in(7'b0000100, 0, 16'h0);
    step(); set_in(7'b0000100, 0, 16'h0);
    step(); set_in(7'b1010100, 0, 16'h0);
    rst = 1'b1;
    #1;
    chk("rstdrain_outs", {26'd0, outs()}, 0);
    chk("rstdrain_id", {16'd0, error_id_o}, 0);
    step(); rst = 1'b0; set_in(7'b1010000, 0, 16'h9);
    @(negedge clk);
    chk("post_rst_aw", {26'd0, outs()}, {26'd0, 6'b110100});
    step(); set_in(7'b0010110, 0, 16'h0);
    @(negedge clk);
    chk("post_rst_w", {26'd0, outs()}, {26'd0, 6'b100000});
    step();
    @(negedge clk);
    chk("post_rst_noreq", {26'd0, outs()}, {26'd0, 6'b100000});

`ifdef AXI_DECERR_STATS_EN
    step(); rst = 1'b1; set_in(7'b0000000, 0, 16'h0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("st_cnt0", {16'd0, err_count_o}, 0);
    step(); set_in(7'b1100000, 3, 16'h44);
    step(); set_in(7'b0000100, 0, 16'h0);
    step(); set_in(7'b0000110, 0, 16'h0);
    step(); set_in(7'b0000000, 0, 16'h0);
    @(negedge clk);
    chk("st_reqb", {26'd0, outs()}, {26'd0, 6'b000001});
    chk("st_mis", {31'd0, len_mismatch_o}, 1);
    chk("st_cnt1", {16'd0, err_count_o}, 1);
    step(); set_in(7'b0000001, 0, 16'h0);
    step(); set_in(7'b0000000, 0, 16'h0);
    step();
    @(negedge clk);
    chk("st_sticky", {31'd0, len_mismatch_o}, 1);
`endif

    // Randomized traffic against the burst model.
    step(); rst = 1'b1; model_reset();
    step(); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step();
      rst            = ($urandom % 300) == 0;
      awvalid_i      = $urandom % 2;
      aw_dec_err_i   = ($urandom % 3) == 0;
      aw_fwd_ready_i = $urandom % 2;
      full_counter_i = ($urandom % 4) == 0;
      wvalid_i       = $urandom % 2;
      wlast_i        = ($urandom % 3) == 0;
      error_gnt_i    = $urandom % 2;
      outstanding_trans_i = ($urandom % 4) == 0;
      awlen_i        = 8'($urandom % 4);
      awid_i         = 16'($urandom);
      awuser_i       = 6'($urandom);
      if (rst) model_reset();
      @(negedge clk);
      model_eval(e, eid, eu);
      chk("rand_outs", {26'd0, outs()}, {26'd0, e});
      chk("rand_id", {16'd0, error_id_o}, {16'd0, eid});
      chk("rand_user", {26'd0, error_user_o}, {26'd0, eu});
`ifdef AXI_DECERR_STATS_EN
      chk("rand_cnt", {16'd0, err_count_o}, m_cnt);
      chk("rand_mis", {31'd0, len_mismatch_o}, {31'd0, m_mis});
`endif
      if (!rst) model_step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
